// File: rtl/calc_dsp_selftest_if.sv
// rtl/calc_dsp_selftest_if.sv - status bundle of the MAC self-test block
interface calc_dsp_selftest_if;
  logic correct;
  logic done;

  modport master (output correct, output done);
  modport slave  (input  correct, input  done);
endinterface

// File: rtl/calc_dsp_selftest.sv
// rtl/calc_dsp_selftest.sv - repeating sum-of-products MAC self-test
// Computes sum i*(i+1) for i < N_ITER through a 3-stage MAC pipeline and checks it.
module calc_dsp_selftest #(
  parameter int unsigned      N_ITER   = 1000,
  parameter int unsigned      ACC_W    = 32,
  parameter logic [ACC_W-1:0] EXPECTED = ACC_W'(333333000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_dsp_selftest_if.master  status
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CHECK
  } state_t;

  localparam logic [15:0] LAST_I = 16'(N_ITER - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_issue;
  logic               w_clear;
  logic               w_check;
  logic               r_drain;
  logic [15:0]        r_i;
  logic [15:0]        r_a;
  logic [15:0]        r_b;
  logic               r_v1;
  logic [31:0]        r_prod;
  logic               r_v2;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_prod_ext;
  logic               r_correct;
  logic               r_done;

  generate
    if (ACC_W > 32) begin : g_prod_zext
      assign w_prod_ext = {{(ACC_W - 32){1'b0}}, r_prod};
    end else begin : g_prod_trunc
      assign w_prod_ext = r_prod[ACC_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_clear = 1'b0;
    w_check = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (r_i == LAST_I) w_next = S_DRAIN;
      end
      // Two drain cycles flush the operand and product stages into acc.
      S_DRAIN: begin
        if (r_drain) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_check = 1'b1;
        w_next  = S_CLEAR;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_v2   <= 1'b0;
      r_acc  <= '0;
    end else if (w_clear) begin
      r_i   <= '0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_acc <= '0;
    end else begin
      r_v1 <= w_issue;
      if (w_issue) begin
        r_a <= r_i;
        r_b <= r_i + 16'd1;
        r_i <= r_i + 16'd1;
      end
      r_v2 <= r_v1;
      if (r_v1) r_prod <= {16'd0, r_a} * {16'd0, r_b};
      if (r_v2) r_acc <= r_acc + w_prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_correct <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_check;
      if (w_check) r_correct <= (r_acc == EXPECTED);
    end
  end

  assign status.correct = r_correct;
  assign status.done    = r_done;

endmodule

// File: tb/tb_calc_dsp_selftest.sv
// tb/tb_calc_dsp_selftest.sv - directed vector bench for calc_dsp_selftest
module tb_calc_dsp_selftest;

  localparam int N_EDGES = 4100;
  localparam int N_DUT   = 5;

  typedef struct {
    int   dut;
    int   edge_n;
    logic exp_done;
    logic exp_corr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_def_n;

  always #5 clk = ~clk;

  calc_dsp_selftest_if if_def ();
  calc_dsp_selftest_if if_n4 ();
  calc_dsp_selftest_if if_n4b ();
  calc_dsp_selftest_if if_wrap ();
  calc_dsp_selftest_if if_n1 ();

  calc_dsp_selftest u_def (
    .clk    (clk),
    .rst_n  (rst_def_n),
    .status (if_def.master)
  );

  calc_dsp_selftest #(.N_ITER(4), .ACC_W(32), .EXPECTED(32'd20)) u_n4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .status (if_n4.master)
  );

  calc_dsp_selftest #(.N_ITER(4), .ACC_W(32), .EXPECTED(32'd21)) u_n4b (
    .clk    (clk),
    .rst_n  (rst_n),
    .status (if_n4b.master)
  );

  calc_dsp_selftest #(.N_ITER(100), .ACC_W(16), .EXPECTED(16'd5620)) u_wrap (
    .clk    (clk),
    .rst_n  (rst_n),
    .status (if_wrap.master)
  );

  calc_dsp_selftest #(.N_ITER(1), .ACC_W(32), .EXPECTED(32'd0)) u_n1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .status (if_n1.master)
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  logic done_h [N_DUT][N_EDGES+1];
  logic corr_h [N_DUT][N_EDGES+1];
  int   period [N_DUT] = '{1004, 8, 8, 104, 5};
  bit   good   [N_DUT] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  vec_t vecs[$];

  task automatic sample(input int k);
    done_h[0][k] = if_def.done;   corr_h[0][k] = if_def.correct;
    done_h[1][k] = if_n4.done;    corr_h[1][k] = if_n4.correct;
    done_h[2][k] = if_n4b.done;   corr_h[2][k] = if_n4b.correct;
    done_h[3][k] = if_wrap.done;  corr_h[3][k] = if_wrap.correct;
    done_h[4][k] = if_n1.done;    corr_h[4][k] = if_n1.correct;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    // Reset state for every instance at edge 0.
    for (int d = 0; d < N_DUT; d++) vecs.push_back('{d, 0, 1'b0, 1'b0});
    vecs.push_back('{0, 1003, 1'b0, 1'b0});
    vecs.push_back('{0, 1004, 1'b1, 1'b1});
    vecs.push_back('{0, 1005, 1'b0, 1'b1});
    vecs.push_back('{0, 2008, 1'b1, 1'b1});
    vecs.push_back('{0, 3012, 1'b1, 1'b1});
    vecs.push_back('{0, 4016, 1'b1, 1'b1});
    vecs.push_back('{0, 4017, 1'b0, 1'b1});
    vecs.push_back('{1, 7,    1'b0, 1'b0});
    vecs.push_back('{1, 8,    1'b1, 1'b1});
    vecs.push_back('{1, 9,    1'b0, 1'b1});
    vecs.push_back('{1, 15,   1'b0, 1'b1});
    vecs.push_back('{1, 16,   1'b1, 1'b1});
    vecs.push_back('{2, 8,    1'b1, 1'b0});
    vecs.push_back('{2, 16,   1'b1, 1'b0});
    vecs.push_back('{3, 103,  1'b0, 1'b0});
    vecs.push_back('{3, 104,  1'b1, 1'b1});
    vecs.push_back('{4, 4,    1'b0, 1'b0});
    vecs.push_back('{4, 5,    1'b1, 1'b1});
    vecs.push_back('{4, 6,    1'b0, 1'b1});
    vecs.push_back('{4, 10,   1'b1, 1'b1});

    rst_n     = 1'b0;
    rst_def_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 sample(0);
    @(negedge clk);
    rst_n     = 1'b1;
    rst_def_n = 1'b1;
    for (int k = 1; k <= N_EDGES; k++) begin
      @(posedge clk);
      #1 sample(k);
    end

    foreach (vecs[v]) begin
      check_bit($sformatf("vec%0d dut%0d E%0d done", v, vecs[v].dut, vecs[v].edge_n),
                done_h[vecs[v].dut][vecs[v].edge_n], vecs[v].exp_done);
      check_bit($sformatf("vec%0d dut%0d E%0d correct", v, vecs[v].dut, vecs[v].edge_n),
                corr_h[vecs[v].dut][vecs[v].edge_n], vecs[v].exp_corr);
    end

    // Whole-trace scan: done exactly on multiples of the period, correct held after first check.
    for (int d = 0; d < N_DUT; d++) begin
      int   bad;
      int   first_bad;
      logic exp_d;
      logic exp_c;
      bad = 0;
      first_bad = -1;
      for (int k = 1; k <= N_EDGES; k++) begin
        exp_d = ((k % period[d]) == 0);
        exp_c = good[d] && (k >= period[d]);
        if (done_h[d][k] !== exp_d || corr_h[d][k] !== exp_c) begin
          bad++;
          if (first_bad < 0) first_bad = k;
        end
      end
      n_vec++;
      if (bad != 0) begin
        n_miss++;
        $display("FAIL scan dut%0d: %0d bad edges, first at E%0d, want 0 bad edges", d, bad, first_bad);
      end
    end

    // Mid-run asynchronous reset of the default instance during pass 2.
    @(negedge clk);
    rst_def_n = 1'b0;
    @(negedge clk);
    rst_def_n = 1'b1;
    for (int k = 1; k <= 1504; k++) begin
      @(posedge clk);
      #1;
    end
    check_bit("pre-reset correct E1504", if_def.correct, 1'b1);
    #2 rst_def_n = 1'b0;
    #1;
    check_bit("async reset correct", if_def.correct, 1'b0);
    check_bit("async reset done", if_def.done, 1'b0);
    @(negedge clk);
    rst_def_n = 1'b1;
    begin
      int   first_done;
      logic corr_1003;
      first_done = 0;
      corr_1003  = 1'bx;
      for (int k = 1; k <= 1100 && first_done == 0; k++) begin
        @(posedge clk);
        #1;
        if (k == 1003) corr_1003 = if_def.correct;
        if (if_def.done === 1'b1) first_done = k;
      end
      check_int("post-reset first done edge", first_done, 1004);
      check_bit("post-reset correct E1003", corr_1003, 1'b0);
      check_bit("post-reset correct at done", if_def.correct, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
